// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_ctrl
//  Purpose  : Mode and time-keeping controller for a 4-digit HH:MM display.
//             Sequences RUN / SET_HOUR / SET_MIN from debounced button
//             pulses. Owns the BCD hour/minute/second registers. Produces
//             the per-digit blink mask and the colon enable for the display
//             multiplexer.
//  Ports    : clk        - system clock
//             rst        - asynchronous active-high reset
//             sec_tick   - one-cycle pulse, once per second
//             btn_mode   - one-cycle pulse, advances mode
//             btn_up     - one-cycle pulse, increments the selected field
//             btn_down   - one-cycle pulse, decrements the selected field
//             hour_bcd   - hours,   BCD 00..23
//             min_bcd    - minutes, BCD 00..59
//             sec_bcd    - seconds, BCD 00..59
//             mode       - 00 RUN, 01 SET_HOUR, 10 SET_MIN
//             blink_mask - 1 blanks a digit (bit3 hour tens .. bit0 min units)
//             colon      - colon / decimal point enable
//  Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int BLINK_DIV    = 25000000,
    parameter int IDLE_TIMEOUT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic [3:0] blink_mask,
    output logic       colon
);

    localparam logic [31:0] c_BLINK_LAST = 32'(BLINK_DIV - 1);
    localparam logic [7:0]  c_IDLE_LIMIT = 8'(IDLE_TIMEOUT);
    localparam logic [7:0]  c_HOUR_MAX   = 8'h23;
    localparam logic [7:0]  c_MIN_MAX    = 8'h59;
    localparam logic [7:0]  c_SEC_MAX    = 8'h59;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_hour;
    logic [7:0]  r_min;
    logic [7:0]  r_sec;
    logic [31:0] r_blink_cnt;
    logic        r_phase;
    logic [7:0]  r_idle_cnt;
    logic [3:0]  r_blink_mask;
    logic        r_colon;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t      w_state_next;
    logic [7:0]  w_hour_next;
    logic [7:0]  w_min_next;
    logic [7:0]  w_sec_next;
    logic [31:0] w_blink_next;
    logic        w_phase_next;
    logic [7:0]  w_idle_next;
    logic [3:0]  w_mask_next;
    logic        w_colon_next;

    // A single up or down pulse is an edit; both together cancel out.
    logic w_adj_up;
    logic w_adj_dn;
    logic w_field_btn;

    assign w_adj_up    = btn_up & ~btn_down;
    assign w_adj_dn    = btn_down & ~btn_up;
    assign w_field_btn = btn_up | btn_down;

    // ------------------------------------------------------------------------
    // Per-digit BCD increment / decrement with wrap at the field limit.
    // Inputs are always legal BCD, so the units digit never exceeds 9.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] res;
        if (v == max_v) begin
            res = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            res = {v[7:4] + 4'd1, 4'd0};
        end else begin
            res = {v[7:4], v[3:0] + 4'd1};
        end
        return res;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] res;
        if (v == 8'h00) begin
            res = max_v;
        end else if (v[3:0] == 4'd0) begin
            res = {v[7:4] - 4'd1, 4'd9};
        end else begin
            res = {v[7:4], v[3:0] - 4'd1};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_hour       <= 8'h00;
            r_min        <= 8'h00;
            r_sec        <= 8'h00;
            r_blink_cnt  <= 32'd0;
            r_phase      <= 1'b0;
            r_idle_cnt   <= 8'd0;
            r_blink_mask <= 4'b0000;
            r_colon      <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_hour       <= w_hour_next;
            r_min        <= w_min_next;
            r_sec        <= w_sec_next;
            r_blink_cnt  <= w_blink_next;
            r_phase      <= w_phase_next;
            r_idle_cnt   <= w_idle_next;
            r_blink_mask <= w_mask_next;
            r_colon      <= w_colon_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_hour_next  = r_hour;
        w_min_next   = r_min;
        w_sec_next   = r_sec;
        w_blink_next = r_blink_cnt;
        w_phase_next = r_phase;
        w_idle_next  = r_idle_cnt;
        w_mask_next  = 4'b0000;
        w_colon_next = 1'b1;

        case (r_state)
            ST_RUN: begin
                // Blink and idle bookkeeping rest at zero outside SET states,
                // so entering a SET state always starts with digits visible.
                w_blink_next = 32'd0;
                w_phase_next = 1'b0;
                w_idle_next  = 8'd0;
                if (btn_mode) begin
                    w_state_next = ST_SET_HOUR;
                end else if (sec_tick) begin
                    // Full seconds->minutes->hours ripple in one cycle.
                    w_sec_next = bcd_inc(r_sec, c_SEC_MAX);
                    if (r_sec == c_SEC_MAX) begin
                        w_min_next = bcd_inc(r_min, c_MIN_MAX);
                        if (r_min == c_MIN_MAX) begin
                            w_hour_next = bcd_inc(r_hour, c_HOUR_MAX);
                        end
                    end
                end
            end

            ST_SET_HOUR, ST_SET_MIN: begin
                // Free-running blink timebase; overridden below by buttons.
                if (r_blink_cnt == c_BLINK_LAST) begin
                    w_blink_next = 32'd0;
                    w_phase_next = ~r_phase;
                end else begin
                    w_blink_next = r_blink_cnt + 32'd1;
                end

                if (btn_mode) begin
                    // Mode wins over any concurrent up/down pulse.
                    w_idle_next  = 8'd0;
                    w_blink_next = 32'd0;
                    w_phase_next = 1'b0;
                    if (r_state == ST_SET_HOUR) begin
                        w_state_next = ST_SET_MIN;
                    end else begin
                        w_state_next = ST_RUN;
                        w_sec_next   = 8'h00;
                    end
                end else if (w_field_btn) begin
                    // Any button activity defers the timeout, even a
                    // cancelled up+down pair. A button also beats a
                    // coincident sec_tick, so no timeout can fire here.
                    w_idle_next = 8'd0;
                    if (w_adj_up || w_adj_dn) begin
                        w_blink_next = 32'd0;
                        w_phase_next = 1'b0;
                        if (r_state == ST_SET_HOUR) begin
                            w_hour_next = w_adj_up ? bcd_inc(r_hour, c_HOUR_MAX)
                                                   : bcd_dec(r_hour, c_HOUR_MAX);
                        end else begin
                            w_min_next  = w_adj_up ? bcd_inc(r_min, c_MIN_MAX)
                                                   : bcd_dec(r_min, c_MIN_MAX);
                        end
                    end
                end else if (sec_tick) begin
                    // Time stays frozen; the tick only feeds the idle timer.
                    if (r_idle_cnt + 8'd1 == c_IDLE_LIMIT) begin
                        w_state_next = ST_RUN;
                        w_sec_next   = 8'h00;
                        w_idle_next  = 8'd0;
                    end else begin
                        w_idle_next = r_idle_cnt + 8'd1;
                    end
                end
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // Mask and colon are derived from next-state values so the registered
        // outputs line up with the registered mode/phase/seconds.
        if (w_phase_next && (w_state_next == ST_SET_HOUR)) begin
            w_mask_next = 4'b1100;
        end else if (w_phase_next && (w_state_next == ST_SET_MIN)) begin
            w_mask_next = 4'b0011;
        end

        if (w_state_next == ST_RUN) begin
            w_colon_next = ~w_sec_next[0];
        end
    end

    assign hour_bcd   = r_hour;
    assign min_bcd    = r_min;
    assign sec_bcd    = r_sec;
    assign mode       = r_state;
    assign blink_mask = r_blink_mask;
    assign colon      = r_colon;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_set_ctrl
//  Purpose  : Directed self-checking bench for clock_set_ctrl, run with
//             BLINK_DIV=4 and IDLE_TIMEOUT=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

    logic       clk;
    logic       rst;
    logic       sec_tick;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] mode;
    logic [3:0] blink_mask;
    logic       colon;

    int n_checks;
    int n_errors;

    clock_set_ctrl #(
        .BLINK_DIV    (4),
        .IDLE_TIMEOUT (3)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .hour_bcd   (hour_bcd),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .mode       (mode),
        .blink_mask (blink_mask),
        .colon      (colon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at a negedge for one cycle; return on the next negedge,
    // by which time the DUT has registered the effect of the pulse.
    task automatic pulse(input logic m, input logic u, input logic d, input logic t);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        sec_tick = t;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        sec_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
            n_errors++;
            $display("FAIL reset_time got %h:%h:%h want 00:00:00", hour_bcd, min_bcd, sec_bcd);
        end
        n_checks++;
        if ({mode, blink_mask, colon} !== 7'b00_0000_1) begin
            n_errors++;
            $display("FAIL reset_ctrl got mode=%b mask=%b colon=%b want 00 0000 1", mode, blink_mask, colon);
        end
    endtask

    task automatic test_sec_carry();
        do_reset();
        repeat (59) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({min_bcd, sec_bcd, colon} !== {8'h00, 8'h59, 1'b0}) begin
            n_errors++;
            $display("FAIL sec59 got min=%h sec=%h colon=%b want 00 59 0", min_bcd, sec_bcd, colon);
        end
        // Up/down are ignored in RUN.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, mode} !== {8'h00, 8'h00, 8'h59, 2'b00}) begin
            n_errors++;
            $display("FAIL run_ignore_btn got %h:%h:%h mode=%b want 00:00:59 00", hour_bcd, min_bcd, sec_bcd, mode);
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({min_bcd, sec_bcd, colon} !== {8'h01, 8'h00, 1'b1}) begin
            n_errors++;
            $display("FAIL sec_carry got min=%h sec=%h colon=%b want 01 00 1", min_bcd, sec_bcd, colon);
        end
    endtask

    task automatic test_set_wrap();
        do_reset();
        repeat (5) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({mode, sec_bcd, blink_mask, colon} !== {2'b01, 8'h05, 4'b0000, 1'b1}) begin
            n_errors++;
            $display("FAIL enter_set_hour got mode=%b sec=%h mask=%b colon=%b want 01 05 0000 1", mode, sec_bcd, blink_mask, colon);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (hour_bcd !== 8'h23) begin
            n_errors++;
            $display("FAIL hour_down_wrap got %h want 23", hour_bcd);
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (hour_bcd !== 8'h00) begin
            n_errors++;
            $display("FAIL hour_up_wrap got %h want 00", hour_bcd);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({mode, hour_bcd} !== {2'b10, 8'h23}) begin
            n_errors++;
            $display("FAIL enter_set_min got mode=%b hour=%h want 10 23", mode, hour_bcd);
        end
        repeat (10) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (min_bcd !== 8'h10) begin
            n_errors++;
            $display("FAIL min_units_carry got %h want 10", min_bcd);
        end
        repeat (50) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({min_bcd, hour_bcd} !== {8'h00, 8'h23}) begin
            n_errors++;
            $display("FAIL min_up_wrap got min=%h hour=%h want 00 23", min_bcd, hour_bcd);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({min_bcd, hour_bcd} !== {8'h59, 8'h23}) begin
            n_errors++;
            $display("FAIL min_down_wrap got min=%h hour=%h want 59 23", min_bcd, hour_bcd);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (min_bcd !== 8'h49) begin
            n_errors++;
            $display("FAIL min_tens_borrow got %h want 49", min_bcd);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd, colon} !== {2'b00, 8'h23, 8'h49, 8'h00, 1'b1}) begin
            n_errors++;
            $display("FAIL exit_to_run got mode=%b %h:%h:%h colon=%b want 00 23:49:00 1", mode, hour_bcd, min_bcd, sec_bcd, colon);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (59) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, mode} !== {8'h23, 8'h59, 8'h59, 2'b00}) begin
            n_errors++;
            $display("FAIL preload got %h:%h:%h mode=%b want 23:59:59 00", hour_bcd, min_bcd, sec_bcd, mode);
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
            n_errors++;
            $display("FAIL day_rollover got %h:%h:%h want 00:00:00", hour_bcd, min_bcd, sec_bcd);
        end
    endtask

    task automatic test_blink();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (blink_mask !== 4'b0000) begin
                n_errors++;
                $display("FAIL blink_show%0d got %b want 0000", i, blink_mask);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({blink_mask, colon} !== {4'b1100, 1'b1}) begin
                n_errors++;
                $display("FAIL blink_blank%0d got mask=%b colon=%b want 1100 1", i, blink_mask, colon);
            end
            @(negedge clk);
        end
        n_checks++;
        if (blink_mask !== 4'b0000) begin
            n_errors++;
            $display("FAIL blink_reshow got %b want 0000", blink_mask);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (blink_mask !== 4'b1100) begin
            n_errors++;
            $display("FAIL blink_blank_again got %b want 1100", blink_mask);
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (hour_bcd !== 8'h01) begin
            n_errors++;
            $display("FAIL blink_edit_hour got %h want 01", hour_bcd);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (blink_mask !== 4'b0000) begin
                n_errors++;
                $display("FAIL blink_restart%0d got %b want 0000", i, blink_mask);
            end
            @(negedge clk);
        end
        n_checks++;
        if (blink_mask !== 4'b1100) begin
            n_errors++;
            $display("FAIL blink_after_restart got %b want 1100", blink_mask);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({mode, blink_mask} !== {2'b10, 4'b0011}) begin
            n_errors++;
            $display("FAIL blink_min got mode=%b mask=%b want 10 0011", mode, blink_mask);
        end
    endtask

    task automatic test_idle();
        do_reset();
        repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({mode, sec_bcd} !== {2'b10, 8'h03}) begin
            n_errors++;
            $display("FAIL idle_frozen got mode=%b sec=%h want 10 03", mode, sec_bcd);
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({mode, hour_bcd, min_bcd, sec_bcd} !== {2'b00, 8'h00, 8'h00, 8'h00}) begin
            n_errors++;
            $display("FAIL idle_timeout got mode=%b %h:%h:%h want 00 00:00:00", mode, hour_bcd, min_bcd, sec_bcd);
        end
        // Button on the final tick wins; the count restarts from zero.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({mode, hour_bcd} !== {2'b01, 8'h01}) begin
            n_errors++;
            $display("FAIL idle_btn_wins got mode=%b hour=%h want 01 01", mode, hour_bcd);
        end
        repeat (2) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (mode !== 2'b01) begin
            n_errors++;
            $display("FAIL idle_cleared got mode=%b want 01", mode);
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({mode, hour_bcd} !== {2'b00, 8'h01}) begin
            n_errors++;
            $display("FAIL idle_timeout2 got mode=%b hour=%h want 00 01", mode, hour_bcd);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({mode, min_bcd} !== {2'b10, 8'h01}) begin
            n_errors++;
            $display("FAIL up_down_cancel got mode=%b min=%h want 10 01", mode, min_bcd);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({mode, hour_bcd, min_bcd} !== {2'b10, 8'h01, 8'h01}) begin
            n_errors++;
            $display("FAIL mode_beats_up got mode=%b hour=%h min=%h want 10 01 01", mode, hour_bcd, min_bcd);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        // Reset lands mid-cycle, checked before the next rising edge.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, mode, blink_mask, colon} !== {24'h000000, 2'b00, 4'b0000, 1'b1}) begin
            n_errors++;
            $display("FAIL async_reset got %h:%h:%h mode=%b mask=%b colon=%b want 00:00:00 00 0000 1",
                     hour_bcd, min_bcd, sec_bcd, mode, blink_mask, colon);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        sec_tick = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        test_reset();
        test_sec_carry();
        test_set_wrap();
        test_rollover();
        test_blink();
        test_idle();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
